// File: rtl/mag_sq_accum_pkg.sv
// Shared types and sizing helpers for the magnitude-squared accumulator.
package mag_sq_accum_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DRAIN_CYCLES = 2;

  // Accumulator width: full-scale square sum (2W bits) grown by log2 of the window.
  function automatic int out_w(input int data_width, input int acc_len);
    return 2 * data_width + $clog2(acc_len);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_sq_lane.sv
// One channel of the energy datapath: square, sum, accumulate.
// With MAG_SQ_ACCUM_ARGMAX_EN the next-cycle accumulator value is exported.
module mag_sq_lane
  import mag_sq_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_LEN    = 16,
  localparam int OUT_W     = out_w(DATA_WIDTH, ACC_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_vld,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] re,
  input  logic signed [DATA_WIDTH-1:0] im,
  output logic [OUT_W-1:0]             acc
`ifdef MAG_SQ_ACCUM_ARGMAX_EN
  , output logic [OUT_W-1:0]           acc_nxt
`endif
);

  localparam int SQ_W = 2 * DATA_WIDTH;

  logic signed [SQ_W-1:0] re_x;
  logic signed [SQ_W-1:0] im_x;
  logic [SQ_W-1:0]        sq_re_d;
  logic [SQ_W-1:0]        sq_im_d;
  logic [SQ_W-1:0]        sq_re_q;
  logic [SQ_W-1:0]        sq_im_q;
  logic [SQ_W-1:0]        sum_q;
  logic                   s1_vld;
  logic                   s2_vld;
  logic [OUT_W-1:0]       acc_d;
  logic [OUT_W-1:0]       acc_q;

  // Sign-extend first so the product is formed at full 2W width.
  assign re_x    = {{DATA_WIDTH{re[DATA_WIDTH-1]}}, re};
  assign im_x    = {{DATA_WIDTH{im[DATA_WIDTH-1]}}, im};
  assign sq_re_d = re_x * re_x;
  assign sq_im_d = im_x * im_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      sq_re_q <= '0;
      sq_im_q <= '0;
      sum_q   <= '0;
    end else begin
      s1_vld <= sample_vld;
      s2_vld <= s1_vld;
      if (sample_vld) begin
        sq_re_q <= sq_re_d;
        sq_im_q <= sq_im_d;
      end
      if (s1_vld) begin
        sum_q <= sq_re_q + sq_im_q;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (s2_vld) begin
      acc_d = acc_q + OUT_W'(sum_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`ifdef MAG_SQ_ACCUM_ARGMAX_EN
  assign acc_nxt = acc_d;
`endif

endmodule

// File: rtl/mag_sq_accum.sv
// Per-channel |x|^2 accumulator over ACC_LEN samples with valid/ready handshakes.
// MAG_SQ_ACCUM_ARGMAX_EN adds best_ch, the index of the most energetic channel.
//
// state | meaning
// ACC   | accepting samples, counting toward ACC_LEN
// DRAIN | input stalled while the last sample flushes through S2/S3
// HOLD  | result presented on out_data until out_ready
module mag_sq_accum
  import mag_sq_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ACC_LEN    = 16,
  localparam int OUT_W     = out_w(DATA_WIDTH, ACC_LEN),
  localparam int BCH_W     = idx_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] real_part,
  input  logic [NUM_CH*DATA_WIDTH-1:0] imag_part,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*OUT_W-1:0]      out_data
`ifdef MAG_SQ_ACCUM_ARGMAX_EN
  , output logic [BCH_W-1:0]           best_ch
`endif
);

  localparam logic [1:0] ACC   = ST_ACC;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] HOLD  = ST_HOLD;

  localparam int CNT_W = $clog2(ACC_LEN);
  localparam int DRN_W = idx_w(DRAIN_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             accept;
  logic             clear;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    clear   = 1'b0;
    case (state_q)
      ACC: begin
        if (accept) begin
          if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
            drn_d   = DRN_W'(DRAIN_CYCLES - 1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Terminal count lands the final sum in the accumulators on the HOLD entry edge.
        if (drn_q == '0) begin
          state_d = HOLD;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // in_ready is registered so it stays low throughout reset and rises on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACC;
      cnt_q    <= '0;
      drn_q    <= '0;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drn_q    <= drn_d;
      in_ready <= (state_d == ACC);
    end
  end

`ifdef MAG_SQ_ACCUM_ARGMAX_EN
  logic [OUT_W-1:0] lane_nxt [NUM_CH];
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    mag_sq_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_LEN    (ACC_LEN)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .sample_vld (accept),
      .clear      (clear),
      .re         (real_part[k*DATA_WIDTH +: DATA_WIDTH]),
      .im         (imag_part[k*DATA_WIDTH +: DATA_WIDTH]),
      .acc        (out_data[k*OUT_W +: OUT_W])
`ifdef MAG_SQ_ACCUM_ARGMAX_EN
      , .acc_nxt  (lane_nxt[k])
`endif
    );
  end

`ifdef MAG_SQ_ACCUM_ARGMAX_EN
  logic [BCH_W-1:0] best_d;
  logic [OUT_W-1:0] best_v;

  // Compare next-cycle values so the index lines up with out_data on HOLD entry.
  always_comb begin
    best_d = '0;
    best_v = lane_nxt[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (lane_nxt[k] > best_v) begin
        best_v = lane_nxt[k];
        best_d = BCH_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_ch <= '0;
    end else if (state_q == DRAIN && state_d == HOLD) begin
      best_ch <= best_d;
    end
  end
`endif

endmodule

// File: doc/mag_sq_accum.md
MAG_SQ_ACCUM -- requirements
Module: mag_sq_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed width of each real/imag input component.
REQ-002 SHALL have parameter NUM_CH, default 4: number of parallel complex channels (antennas).
REQ-003 SHALL have parameter ACC_LEN, default 16: samples summed per result; power of two, minimum 2.
REQ-004 SHALL have one clock; reset is asynchronous and active-high. Ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  input sample vector valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample vector this cycle.
REQ-007 SHALL have port real_part  input  NUM_CH*DATA_WIDTH  signed real components; channel k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port imag_part  input  NUM_CH*DATA_WIDTH  signed imaginary components, same packing.
REQ-009 SHALL have port out_valid  output  1  accumulated result vector valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_data  output  NUM_CH*OUT_W  unsigned energy per channel; OUT_W = 2*DATA_WIDTH + log2(ACC_LEN).

Function
REQ-012 SHALL compute per channel re*re + im*im as an unsigned 2*DATA_WIDTH value: the full-scale case (-2^(W-1))^2 * 2 = 2^(2W-1) fits with no overflow.
REQ-013 SHALL use a 3-stage pipeline per lane: S1 registers both squares, S2 registers their sum, S3 adds the sum into the channel accumulator.
REQ-014 SHALL accept a sample only on a cycle with in_valid && in_ready; samples offered on any other cycle SHALL have no effect.
REQ-015 SHALL use FSM states ACC, DRAIN and HOLD.
REQ-016 ACC: in_ready=1; a sample counter counts accepted samples; acceptance of sample number ACC_LEN moves the FSM to DRAIN.
REQ-017 DRAIN: in_ready=0 for exactly 2 cycles while S2/S3 flush, then the FSM moves to HOLD.
REQ-018 HOLD: out_valid=1, in_ready=0; out_data holds the final accumulator values and SHALL stay stable until out_ready=1.
REQ-019 out_valid SHALL first be visible 3 cycles after the cycle that accepted the last sample.
REQ-020 On the cycle with out_valid && out_ready, the block SHALL clear the accumulators and the counter and return to ACC; in_ready=1 on the next cycle.
REQ-021 Gaps in in_valid during ACC SHALL stretch the accumulation window without corrupting pipeline contents.
REQ-022 An accumulator SHALL never wrap: its maximum, ACC_LEN*2^(2W-1), fits in OUT_W bits.

Reset
REQ-023 While rst=1: FSM=ACC, counter=0, all pipeline registers and accumulators=0, out_valid=0, in_ready=0 (after release, in_ready=1 from the first clock edge).
REQ-024 Reset asserted mid-window or during HOLD SHALL discard all partial sums; no result SHALL be emitted for that window.

Configuration
REQ-025 Macro MAG_SQ_ACCUM_ARGMAX_EN, when defined, SHALL add output best_ch (width log2(NUM_CH), min 1) giving the index of the largest out_data channel, valid with out_valid; ties resolve to the lowest index.
REQ-026 With the macro defined, best_ch SHALL be registered on entry to HOLD and SHALL reset to 0.
REQ-027 Without the macro, port best_ch and the compare logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package mag_sq_accum_pkg SHALL hold the FSM state enum, the OUT_W width function and DRAIN_CYCLES=2.
REQ-029 The per-channel square/sum/accumulate datapath SHALL be a sub-module mag_sq_lane, instantiated NUM_CH times via generate; the FSM and counter are shared.

Verification (DATA_WIDTH=8, NUM_CH=2, ACC_LEN=4)
REQ-030 ch0=(3,4), ch1=(1,0) for 4 consecutive cycles, out_ready=1 -> out_valid 3 cycles after the last accept; ch0=100, ch1=4; best_ch=0.
REQ-031 ch1=(-128,-128) x4 -> ch1=131072 (full scale, no wrap); best_ch=1.
REQ-032 out_ready held low 5 cycles in HOLD -> out_data and best_ch stable, in_ready=0; accepting the result -> in_ready=1 on the next cycle.
REQ-033 in_valid pattern 1,0,0,1,1,0,1 with ch0=(2,0) -> exactly 4 accepts, ch0=16.
REQ-034 rst pulsed after 2 accepts, then 4 samples of ch0=(1,1) -> ch0=8; no stale sum.
REQ-035 Equal energies on both channels -> best_ch=0.
